seq_detect_param: RTL and testbench
===================================

// Module: seq_detect_param
// PURPOSE
//  Programmable serial bit-pattern detector, Mealy-style: match asserts combinationally
//  in the cycle the final pattern bit is presented. Successor to the fixed 4-bit detector.
//  Pattern length is set by parameter; pattern and overlap mode are loaded at run time.
//  A saturating match counter is included. Sits on a serial input stream with a valid qualifier.
// PARAMETERS
//  PAT_LEN  4  pattern length in bits; legal range 2..32
//  CNT_W    8  width of match_count
// PORTS
//  Clk          in   1        clock, rising edge
//  reset        in   1        asynchronous, active-low reset
//  cfg_load     in   1        load cfg_pattern/cfg_overlap and restart detection
//  cfg_pattern  in   PAT_LEN  pattern; bit PAT_LEN-1 is received first, bit 0 last
//  cfg_overlap  in   1        1 = overlapping matches allowed; 0 = non-overlapping
//  data_valid   in   1        data_in is valid this cycle
//  data_in      in   1        serial data bit
//  cnt_clr      in   1        synchronous clear of match_count and count_sat
//  match        out  1        combinational: current bit completes the pattern
//  match_count  out  CNT_W    number of matches since reset/cnt_clr, saturating
//  count_sat    out  1        sticky: match_count has reached all-ones
//  armed        out  1        state == RUN (history full, matches possible)
// BEHAVIOUR
//  Reset (reset==0, async): state=UNCFG, pattern reg=0, overlap reg=0, hist=0, fill=0,
//   match_count=0, count_sat=0. Consequently match=0 and armed=0.
//  Storage: hist[PAT_LEN-2:0] holds the last valid bits, newest in bit 0.
//   fill counts valid bits held and saturates at PAT_LEN-1.
//  FSM states:
//   UNCFG: data ignored; match=0. cfg_load -> FILL.
//   FILL: a valid bit shifts into hist and increments fill.
//    Move to RUN when fill reaches PAT_LEN-1.
//   RUN: match = data_valid & ({hist,data_in}==pattern). Every valid bit shifts into hist.
//  On match in RUN:
//   overlap=1: hist keeps the shifted value; stay in RUN.
//   overlap=0: fill<=0, hist<=0; go to FILL. The matched bits are not reused.
//  cfg_load (any state): latch cfg_pattern/cfg_overlap, fill<=0, hist<=0, then -> FILL.
//   match is forced 0 in the load cycle; a coincident data bit is discarded.
//   match_count is not affected.
//  data_valid=0: no shift, no state change, match=0.
//  Counter: on match, match_count += 1 unless it is all-ones (it holds at max).
//   count_sat sets when match_count becomes all-ones and stays set until cnt_clr.
//   cnt_clr with a simultaneous match: clear wins, match_count=0, count_sat=0; match still asserts.
//  Latency: match has 0 cycles latency (same cycle as the last bit).
//   match_count updates at the next rising Clk edge.
//  Async reset mid-stream: all state is lost. Configuration must be reloaded.
//  Next-state and output logic are fully combinational from state, hist and inputs; no latches.
// TESTING
//  1 Reset then stream 1,1,0,1 with no cfg_load -> match never 1, armed=0, count=0.
//  2 PAT_LEN=4, load 4'b1101 overlap=1, stream 1101101 -> match on bits 4 and 7; count=2.
//  3 Same stream with overlap=0 -> match on bit 4 only; 1101 1101 -> matches on bits 4 and 8.
//  4 data_valid gaps inside 1_1_0_1 (valid=0 idle cycles between bits) -> single match on
//    last valid bit; match=0 in all idle cycles.
//  5 cfg_load asserted with data_valid=1 after bits 110 -> bit dropped, armed=0.
//    New pattern then needs 4 fresh bits before any match.
//  6 CNT_W=2: 3 matches -> count=3, count_sat=1; 4th match holds 3.
//    cnt_clr together with a 5th match -> count=0, sat=0, match=1. Async reset mid-FILL -> all outputs 0.

Source files
------------

// File: rtl/seq_detect_param.sv
// ---------------------------------------------------------------------------
// seq_detect_param
// Programmable serial bit-pattern detector with a Mealy-style match output.
// The pattern length is fixed at elaboration time. The pattern and the overlap
// mode are loaded at run time. Every match also advances a saturating match
// counter.
//
// Parameters:
//   PAT_LEN      pattern length in bits (2..32)
//   CNT_W        width of match_count
// Ports:
//   Clk          clock, rising edge
//   reset        asynchronous, active-low reset
//   cfg_load     latch cfg_pattern/cfg_overlap and restart detection
//   cfg_pattern  pattern, bit PAT_LEN-1 received first, bit 0 last
//   cfg_overlap  1 = overlapping matches allowed, 0 = matched bits consumed
//   data_valid   data_in qualifier
//   data_in      serial data bit
//   cnt_clr      synchronous clear of match_count and count_sat
//   match        combinational, current valid bit completes the pattern
//   match_count  saturating number of matches since reset/cnt_clr
//   count_sat    sticky flag, match_count has reached all-ones
//   armed        history is full and matches are possible
// ---------------------------------------------------------------------------
module seq_detect_param #(
   parameter int PAT_LEN = 4,
   parameter int CNT_W   = 8
) (
   input  logic               Clk,
   input  logic               reset,
   input  logic               cfg_load,
   input  logic [PAT_LEN-1:0] cfg_pattern,
   input  logic               cfg_overlap,
   input  logic               data_valid,
   input  logic               data_in,
   input  logic               cnt_clr,
   output logic               match,
   output logic [CNT_W-1:0]   match_count,
   output logic               count_sat,
   output logic               armed
);

   localparam int FILL_W = $clog2(PAT_LEN);
   localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_LEN - 1);

   typedef enum logic [1:0] {
      UNCFG = 2'd0,
      FILL  = 2'd1,
      RUN   = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [PAT_LEN-1:0]   pattern_q, pattern_d;
   logic                 overlap_q, overlap_d;
   logic [PAT_LEN-2:0]   hist_q, hist_d;
   logic [FILL_W-1:0]    fill_q, fill_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic                 sat_q, sat_d;
   logic [PAT_LEN-1:0]   window;
   logic [CNT_W-1:0]     countInc;

   // The candidate word is the stored history with the incoming bit appended as
   // the newest (least significant) bit. Its low PAT_LEN-1 bits are also what
   // the history becomes after a shift.
   assign window   = {hist_q, data_in};
   assign countInc = count_q + CNT_W'(1);

   // All state is held in these registers. The reset drops the configuration
   // as well, so the detector sits in UNCFG until someone loads a pattern again.
   always_ff @(posedge Clk or negedge reset) begin
      if (!reset) begin
         state_q   <= UNCFG;
         pattern_q <= '0;
         overlap_q <= 1'b0;
         hist_q    <= '0;
         fill_q    <= '0;
         count_q   <= '0;
         sat_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         pattern_q <= pattern_d;
         overlap_q <= overlap_d;
         hist_q    <= hist_d;
         fill_q    <= fill_d;
         count_q   <= count_d;
         sat_q     <= sat_d;
      end
   end

   // Next-state and match logic.
   // FILL collects PAT_LEN-1 bits of history before the detector may report a
   // match. RUN compares each valid bit against the pattern.
   // In non-overlap mode a match throws away the history, so the next match
   // needs a complete set of fresh bits.
   // A cfg_load overrides everything else and discards any bit that arrives in
   // the same cycle.
   always_comb begin
      state_d   = state_q;
      pattern_d = pattern_q;
      overlap_d = overlap_q;
      hist_d    = hist_q;
      fill_d    = fill_q;
      match     = 1'b0;

      case (state_q)
         UNCFG: begin
         end
         FILL: begin
            if (data_valid) begin
               hist_d = window[PAT_LEN-2:0];
               fill_d = fill_q + FILL_W'(1);
               if (fill_q == FILL_LAST - FILL_W'(1)) begin
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            if (data_valid) begin
               match = (window == pattern_q);
               if (match && !overlap_q) begin
                  hist_d  = '0;
                  fill_d  = '0;
                  state_d = FILL;
               end else begin
                  hist_d = window[PAT_LEN-2:0];
               end
            end
         end
         default: begin
            state_d = UNCFG;
         end
      endcase

      if (cfg_load) begin
         match     = 1'b0;
         pattern_d = cfg_pattern;
         overlap_d = cfg_overlap;
         hist_d    = '0;
         fill_d    = '0;
         state_d   = FILL;
      end
   end

   // Match counter.
   // The count stops at all-ones and count_sat stays set from that point on.
   // If cnt_clr arrives in the same cycle as a match, the clear takes priority.
   always_comb begin
      count_d = count_q;
      sat_d   = sat_q;
      if (cnt_clr) begin
         count_d = '0;
         sat_d   = 1'b0;
      end else if (match && (count_q != {CNT_W{1'b1}})) begin
         count_d = countInc;
         if (countInc == {CNT_W{1'b1}}) begin
            sat_d = 1'b1;
         end
      end
   end

   assign match_count = count_q;
   assign count_sat   = sat_q;
   assign armed       = (state_q == RUN);

endmodule

// File: tb/tb_seq_detect_param.sv
// ---------------------------------------------------------------------------
// tb_seq_detect_param
// Self-checking bench for seq_detect_param.
// Two instances share the same inputs: one with an 8-bit counter and one with
// a 2-bit counter, so that counter saturation is easy to reach.
// The reference model keeps the received bits in a queue. It decides a match
// by comparing the newest PAT_LEN bits with the loaded pattern.
// ---------------------------------------------------------------------------
module tb_seq_detect_param;

   localparam int P = 4;

   logic         Clk;
   logic         reset;
   logic         cfg_load;
   logic [P-1:0] cfg_pattern;
   logic         cfg_overlap;
   logic         data_valid;
   logic         data_in;
   logic         cnt_clr;

   logic         match8, sat8, armed8;
   logic [7:0]   count8;
   logic         matchS, satS, armedS;
   logic [1:0]   countS;

   int checks;
   int passes;

   // Reference model state
   bit           cfgd;
   logic [P-1:0] mPat;
   bit           mOvl;
   bit           q[$];
   int           c8, c2;
   bit           s8, s2;
   bit           expM, expA;

   typedef struct {
      bit           ld;
      logic [P-1:0] pat;
      bit           ovl;
      bit           v;
      bit           d;
      bit           expMatch;
      bit           expArmed;
   } vec_t;

   vec_t tbl[$];

   seq_detect_param #(.PAT_LEN(P), .CNT_W(8)) dut (
      .Clk(Clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
      .cfg_overlap(cfg_overlap), .data_valid(data_valid), .data_in(data_in),
      .cnt_clr(cnt_clr), .match(match8), .match_count(count8),
      .count_sat(sat8), .armed(armed8)
   );

   seq_detect_param #(.PAT_LEN(P), .CNT_W(2)) dutS (
      .Clk(Clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
      .cfg_overlap(cfg_overlap), .data_valid(data_valid), .data_in(data_in),
      .cnt_clr(cnt_clr), .match(matchS), .match_count(countS),
      .count_sat(satS), .armed(armedS)
   );

   // Free-running clock with a 10-unit period.
   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   function automatic vec_t mkVec(bit ld, logic [P-1:0] pat, bit ovl, bit v, bit d,
                                  bit em, bit ea);
      vec_t r;
      r.ld = ld; r.pat = pat; r.ovl = ovl; r.v = v; r.d = d;
      r.expMatch = em; r.expArmed = ea;
      return r;
   endfunction

   // Model match: the detector must be configured, the cycle must not be a
   // load cycle, at least P-1 bits must already be held, and those bits
   // followed by the incoming bit must equal the pattern.
   function automatic bit modelMatch(bit ld, bit v, bit d);
      logic [P-1:0] w;
      if (!cfgd || ld || !v || q.size() < P-1) return 1'b0;
      for (int i = 0; i < P-1; i++) w[P-1-i] = q[q.size()-(P-1)+i];
      w[0] = d;
      return (w == mPat);
   endfunction

   task automatic modelReset();
      cfgd = 0; mPat = '0; mOvl = 0; q.delete();
      c8 = 0; c2 = 0; s8 = 0; s2 = 0;
   endtask

   task automatic checkVal(input string nm, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want)
         $display("[TB] FAIL %s got %0h expected %0h at %0t", nm, got, want, $time);
      else
         passes++;
   endtask

   // Drives one cycle's inputs and lets the combinational outputs settle.
   task automatic applyStimulus(input bit ld, input logic [P-1:0] pat, input bit ovl,
                                input bit v, input bit d, input bit clr);
      cfg_load = ld; cfg_pattern = pat; cfg_overlap = ovl;
      data_valid = v; data_in = d; cnt_clr = clr;
      #1;
      expM = modelMatch(ld, v, d);
      expA = cfgd && (q.size() >= P-1);
   endtask

   // Compares both instances against the model, advances the model through
   // the coming clock edge, and then returns one unit after that edge.
   task automatic checkOutput(input string nm);
      checkVal({nm, "_match"}, match8, expM);
      checkVal({nm, "_armed"}, armed8, expA);
      checkVal({nm, "_cnt8"}, count8, c8);
      checkVal({nm, "_sat8"}, sat8, s8);
      checkVal({nm, "_matchS"}, matchS, expM);
      checkVal({nm, "_armedS"}, armedS, expA);
      checkVal({nm, "_cnt2"}, countS, c2);
      checkVal({nm, "_sat2"}, satS, s2);
      if (cfg_load) begin
         cfgd = 1; mPat = cfg_pattern; mOvl = cfg_overlap; q.delete();
      end else if (cfgd && data_valid) begin
         if (expM && !mOvl) q.delete();
         else begin
            q.push_back(data_in);
            if (q.size() > P-1) void'(q.pop_front());
         end
      end
      if (cnt_clr) begin
         c8 = 0; c2 = 0; s8 = 0; s2 = 0;
      end else if (expM) begin
         if (c8 < 255) c8++;
         if (c8 == 255) s8 = 1;
         if (c2 < 3) c2++;
         if (c2 == 3) s2 = 1;
      end
      @(posedge Clk);
      #1;
   endtask

   task automatic step(input bit ld, input logic [P-1:0] pat, input bit ovl,
                       input bit v, input bit d, input bit clr, input string nm);
      applyStimulus(ld, pat, ovl, v, d, clr);
      checkOutput(nm);
   endtask

   // Feeds n valid bits, most significant bit first.
   task automatic feedBits(input logic [31:0] bits, input int n, input string nm);
      for (int i = n-1; i >= 0; i--) step(0, '0, 0, 1, bits[i], 0, nm);
   endtask

   task automatic doReset();
      reset = 1'b0;
      cfg_load = 0; cfg_pattern = '0; cfg_overlap = 0;
      data_valid = 0; data_in = 0; cnt_clr = 0;
      #2;
      modelReset();
      checkVal("rst_match", match8, 0);
      checkVal("rst_armed", armed8, 0);
      checkVal("rst_cnt8", count8, 0);
      checkVal("rst_sat8", sat8, 0);
      checkVal("rst_cnt2", countS, 0);
      @(posedge Clk);
      #1;
      reset = 1'b1;
   endtask

   initial begin
      checks = 0;
      passes = 0;
      modelReset();
      doReset();

      // Unconfigured: data is ignored
      feedBits(32'b1101, 4, "uncfg");
      checkVal("uncfg_armed", armed8, 0);
      checkVal("uncfg_cnt", count8, 0);

      // Overlap then non-overlap streams, as a table of vectors
      tbl.push_back(mkVec(1, 4'b1101, 1, 0, 0, 0, 0));
      tbl.push_back(mkVec(0, 4'b0000, 0, 1, 1, 0, 0));
      tbl.push_back(mkVec(0, 4'b0000, 0, 1, 1, 0, 0));
      tbl.push_back(mkVec(0, 4'b0000, 0, 1, 0, 0, 0));
      tbl.push_back(mkVec(0, 4'b0000, 0, 1, 1, 1, 1));
      tbl.push_back(mkVec(0, 4'b0000, 0, 1, 1, 0, 1));
      tbl.push_back(mkVec(0, 4'b0000, 0, 1, 0, 0, 1));
      tbl.push_back(mkVec(0, 4'b0000, 0, 1, 1, 1, 1));
      tbl.push_back(mkVec(1, 4'b1101, 0, 0, 0, 0, 1));
      tbl.push_back(mkVec(0, 4'b0000, 0, 1, 1, 0, 0));
      tbl.push_back(mkVec(0, 4'b0000, 0, 1, 1, 0, 0));
      tbl.push_back(mkVec(0, 4'b0000, 0, 1, 0, 0, 0));
      tbl.push_back(mkVec(0, 4'b0000, 0, 1, 1, 1, 1));
      tbl.push_back(mkVec(0, 4'b0000, 0, 1, 1, 0, 0));
      tbl.push_back(mkVec(0, 4'b0000, 0, 1, 0, 0, 0));
      tbl.push_back(mkVec(0, 4'b0000, 0, 1, 1, 0, 0));
      tbl.push_back(mkVec(1, 4'b1101, 0, 0, 0, 0, 1));
      tbl.push_back(mkVec(0, 4'b0000, 0, 1, 1, 0, 0));
      tbl.push_back(mkVec(0, 4'b0000, 0, 1, 1, 0, 0));
      tbl.push_back(mkVec(0, 4'b0000, 0, 1, 0, 0, 0));
      tbl.push_back(mkVec(0, 4'b0000, 0, 1, 1, 1, 1));
      tbl.push_back(mkVec(0, 4'b0000, 0, 1, 1, 0, 0));
      tbl.push_back(mkVec(0, 4'b0000, 0, 1, 1, 0, 0));
      tbl.push_back(mkVec(0, 4'b0000, 0, 1, 0, 0, 0));
      tbl.push_back(mkVec(0, 4'b0000, 0, 1, 1, 1, 1));
      foreach (tbl[i]) begin
         applyStimulus(tbl[i].ld, tbl[i].pat, tbl[i].ovl, tbl[i].v, tbl[i].d, 0);
         checkVal($sformatf("tbl%0d_match", i), match8, tbl[i].expMatch);
         checkVal($sformatf("tbl%0d_armed", i), armed8, tbl[i].expArmed);
         checkOutput($sformatf("tbl%0d", i));
      end
      checkVal("tbl_count", count8, 5);

      // Idle cycles between valid bits: exactly one match
      step(1, 4'b1101, 1, 0, 0, 0, "gap_load");
      step(0, '0, 0, 1, 1, 0, "gap");
      step(0, '0, 0, 0, 0, 0, "gap");
      step(0, '0, 0, 1, 1, 0, "gap");
      step(0, '0, 0, 0, 1, 0, "gap");
      step(0, '0, 0, 0, 0, 0, "gap");
      step(0, '0, 0, 1, 0, 0, "gap");
      step(0, '0, 0, 0, 1, 0, "gap");
      step(0, '0, 0, 1, 1, 0, "gap");
      checkVal("gap_count", count8, 6);

      // A load in the same cycle as a valid bit discards that bit
      step(1, 4'b1101, 1, 0, 0, 0, "ld_load");
      feedBits(32'b110, 3, "ld_pre");
      step(1, 4'b1101, 1, 1, 1, 0, "ld_coinc");
      checkVal("ld_armed", armed8, 0);
      feedBits(32'b110, 3, "ld_fresh");
      checkVal("ld_nomatch", count8, 6);
      feedBits(32'b1, 1, "ld_fresh");
      checkVal("ld_count", count8, 7);

      // Saturation of the narrow counter, then a clear that coincides with a match
      step(0, '0, 0, 0, 0, 1, "sat_clr");
      step(1, 4'b1101, 1, 0, 0, 0, "sat_load");
      feedBits(32'b1101101101, 10, "sat");
      checkVal("sat_cnt3", countS, 3);
      checkVal("sat_flag", satS, 1);
      feedBits(32'b101, 3, "sat_hold");
      checkVal("sat_hold", countS, 3);
      feedBits(32'b10, 2, "sat_pre");
      applyStimulus(0, '0, 0, 1, 1, 1);
      checkVal("clr_match", matchS, 1);
      checkOutput("clr_cyc");
      checkVal("clr_cnt", countS, 0);
      checkVal("clr_sat", satS, 0);

      // Asynchronous reset while filling
      step(1, 4'b0110, 0, 0, 0, 0, "ar_load");
      feedBits(32'b11, 2, "ar_fill");
      reset = 1'b0;
      #2;
      checkVal("ar_match", match8, 0);
      checkVal("ar_armed", armed8, 0);
      checkVal("ar_cnt8", count8, 0);
      checkVal("ar_sat2", satS, 0);
      modelReset();
      @(posedge Clk);
      #1;
      reset = 1'b1;

      // Randomized traffic against the model
      doReset();
      step(1, 4'($urandom), 1'($urandom), 0, 0, 0, "rnd_load");
      for (int n = 0; n < 800; n++) begin
         step(($urandom_range(0, 39) == 0), 4'($urandom), 1'($urandom),
              ($urandom_range(0, 3) != 0), 1'($urandom),
              ($urandom_range(0, 79) == 0), "rnd");
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
